expr_eval: RTL and testbench
============================

EXPR_EVAL -- requirements
Module: expr_eval

Interface
REQ-001 Parameter: VAL_W, default 16, result and accumulator width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: clr  input  1  asynchronous, active-low reset; asserted while 0.
REQ-004 Port: in  input  8  ASCII character, one per accepted cycle.
REQ-005 Port: in_vld  input  1  character strobe; in is consumed only on cycles with in_vld=1.
REQ-006 Port: flush  input  1  synchronous restart; returns the block to the empty state.
REQ-007 Port: ok  output  1  high when the characters accepted so far form a complete expression of the form digit ([+*] digit)*.
REQ-008 Port: value  output  VAL_W  value of the expression accepted so far, '*' binding tighter than '+'.
REQ-009 Port: err  output  1  sticky syntax-error flag.

Function
REQ-010 The block shall implement states EMPTY, NUM, ADD, MUL and ERR, plus two VAL_W accumulator registers: sum and term.
REQ-011 EMPTY + digit d: term=d, sum=0, value=d, ok=1, go to NUM.
REQ-012 NUM + '+': sum=sum+term, ok=0, value held, go to ADD.
REQ-013 NUM + '*': ok=0, value held, go to MUL.
REQ-014 ADD + digit d: term=d, value=sum+d, ok=1, go to NUM.
REQ-015 MUL + digit d: term=term*d, value=sum+term*d, ok=1, go to NUM.
REQ-016 Any character not allowed by REQ-011..015 (including '+' or '*' in EMPTY, ADD or MUL; a digit in NUM; any other byte) shall cause: go to ERR, ok=0, err=1, value=0.
REQ-017 In ERR, all characters shall be ignored; ok=0, err=1 and value=0 shall hold until reset or flush.
REQ-018 Digits are ASCII "0".."9" (0x30..0x39); d = in-0x30.
REQ-019 All arithmetic shall be unsigned modulo 2^VAL_W.
REQ-020 Products shall be truncated to VAL_W bits; there shall be no saturation and no overflow flag.
REQ-021 Outputs shall be registered.
REQ-022 Latency: ok, value and err shall reflect a character on the same rising edge that accepts it (visible the cycle after in_vld is presented).
REQ-023 With in_vld=0, state, accumulators and all outputs shall hold.
REQ-024 flush=1 shall, on the next edge and from any state, force EMPTY, sum=0, term=0, value=0, ok=0 and err=0.
REQ-025 When flush and in_vld are high together, flush wins and the character is discarded.
REQ-026 ok shall never be high while err is high.

Reset
REQ-027 clr=0 shall immediately, without waiting for a clock edge, force state EMPTY, sum=0, term=0, value=0, ok=0 and err=0.
REQ-028 Reset asserted mid-expression shall discard all partial results.
REQ-029 The first character accepted after clr is released shall be treated as the start of a new expression.
REQ-030 Reset deassertion needs no synchronizer inside this block; it is synchronized upstream.

Structure
REQ-031 A shared package expr_pkg shall hold the state enumeration (EMPTY, NUM, ADD, MUL, ERR) and the ASCII constants for "0", "9", "+" and "*".
REQ-032 The checker block and this evaluator shall both use expr_pkg.
REQ-033 One sub-module expr_char_class shall be used: combinational classifier of in into is_digit, is_add, is_mul and digit[3:0].
REQ-034 All state and accumulator registers shall live in expr_eval.

Verification
REQ-035 "1","+","2","*","3", one per cycle with in_vld=1 -> ok sequence 1,0,1,0,1; final value=7; err=0.
REQ-036 "9" followed by "*9" five times (9^6) -> final value=7153 (531441 mod 65536), ok=1.
REQ-037 "1","+","+" -> after the third character ok=0, err=1, value=0; then "5" -> outputs unchanged.
REQ-038 "2", in_vld=0 for 3 cycles with in="+", then "*","4" with in_vld=1 -> value stays 2 through the idle cycles; final value=8.
REQ-039 "3","*" then clr=0 asynchronously mid-cycle -> outputs zero before the next edge; after release, "6" -> value=6, ok=1.
REQ-040 Error state, then flush=1 together with in_vld=1, in="7" -> next cycle EMPTY, value=0, ok=0, err=0; then "7" -> value=7, ok=1.

Source files
------------

// File: rtl/expr_pkg.sv
// -----------------------------------------------------------------------------
// expr_pkg
// Shared definitions for the expression evaluator and its companion checker:
// FSM state encodings and the ASCII codes the character classifier recognises.
// No ports.
// -----------------------------------------------------------------------------
package expr_pkg;

  typedef logic [2:0] state_t;

  // Evaluator states, kept as plain constants so older tools can read them.
  localparam state_t ST_EMPTY = 3'd0;
  localparam state_t ST_NUM   = 3'd1;
  localparam state_t ST_ADD   = 3'd2;
  localparam state_t ST_MUL   = 3'd3;
  localparam state_t ST_ERR   = 3'd4;

  // ASCII characters of interest.
  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_NINE = 8'h39;
  localparam logic [7:0] CH_ADD  = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;

endpackage

// File: rtl/expr_eval_if.sv
// -----------------------------------------------------------------------------
// expr_eval_if
// Character stream and result bundle for expr_eval.
//   in      : ASCII character
//   in_vld  : character strobe
//   flush   : synchronous restart
//   ok      : characters so far form a complete expression
//   value   : value of the expression so far
//   err     : sticky syntax error
// master drives the characters, slave (the evaluator) drives the results.
// -----------------------------------------------------------------------------
interface expr_eval_if #(
  parameter int VAL_W = 16
);

  logic [7:0]       in;
  logic             in_vld;
  logic             flush;
  logic             ok;
  logic [VAL_W-1:0] value;
  logic             err;

  modport master (
    output in,
    output in_vld,
    output flush,
    input  ok,
    input  value,
    input  err
  );

  modport slave (
    input  in,
    input  in_vld,
    input  flush,
    output ok,
    output value,
    output err
  );

endinterface

// File: rtl/expr_char_class.sv
// -----------------------------------------------------------------------------
// expr_char_class
// Combinational classifier for one ASCII character.
//   ch       : input character
//   is_digit : ch is '0'..'9'
//   is_add   : ch is '+'
//   is_mul   : ch is '*'
//   digit    : numeric value of ch when is_digit is set
// -----------------------------------------------------------------------------
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_digit,
  output logic       is_add,
  output logic       is_mul,
  output logic [3:0] digit
);

  assign is_digit = (ch >= CH_ZERO) && (ch <= CH_NINE);
  assign is_add   = (ch == CH_ADD);
  assign is_mul   = (ch == CH_MUL);

  // '0'..'9' are 0x30..0x39, so the low nibble already is the digit value.
  assign digit    = ch[3:0];

endmodule

// File: rtl/expr.sv
// -----------------------------------------------------------------------------
// expr_eval
// Streaming evaluator for expressions of the form digit ([+*] digit)*, with
// '*' binding tighter than '+'. The running sum of finished product terms is
// kept in sum_q and the product term under construction in term_q, so the
// value of any complete prefix is simply sum_q + term_q.
//   clk  : clock, rising edge
//   clr  : asynchronous active-low reset
//   bus  : expr_eval_if slave (in, in_vld, flush -> ok, value, err)
// All arithmetic is unsigned modulo 2^VAL_W; outputs are registered and
// reflect a character on the same edge that accepts it.
// -----------------------------------------------------------------------------
module expr_eval
  import expr_pkg::*;
#(
  parameter int VAL_W = 16
) (
  input  logic       clk,
  input  logic       clr,
  expr_eval_if.slave bus
);

  state_t           state_q, state_d;
  logic [VAL_W-1:0] sum_q,   sum_d;
  logic [VAL_W-1:0] term_q,  term_d;
  logic [VAL_W-1:0] value_q, value_d;
  logic             ok_q,    ok_d;
  logic             err_q,   err_d;

  logic             isDigit;
  logic             isAdd;
  logic             isMul;
  logic [3:0]       digit;
  logic [VAL_W-1:0] digitW;
  logic [VAL_W-1:0] product;

  expr_char_class u_class (
    .ch       (bus.in),
    .is_digit (isDigit),
    .is_add   (isAdd),
    .is_mul   (isMul),
    .digit    (digit)
  );

  assign digitW  = VAL_W'(digit);
  // Truncated product of the pending term and the incoming digit.
  assign product = term_q * digitW;

  // Next-state logic: flush beats a character; anything the grammar does
  // not allow drops into ERR, which then ignores input until restart.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    term_d  = term_q;
    value_d = value_q;
    ok_d    = ok_q;
    err_d   = err_q;

    if (bus.flush) begin
      state_d = ST_EMPTY;
      sum_d   = '0;
      term_d  = '0;
      value_d = '0;
      ok_d    = 1'b0;
      err_d   = 1'b0;
    end else if (bus.in_vld) begin
      case (state_q)
        ST_EMPTY: begin
          if (isDigit) begin
            state_d = ST_NUM;
            sum_d   = '0;
            term_d  = digitW;
            value_d = digitW;
            ok_d    = 1'b1;
          end else begin
            state_d = ST_ERR;
          end
        end
        ST_NUM: begin
          if (isAdd) begin
            state_d = ST_ADD;
            sum_d   = sum_q + term_q;
            ok_d    = 1'b0;
          end else if (isMul) begin
            state_d = ST_MUL;
            ok_d    = 1'b0;
          end else begin
            state_d = ST_ERR;
          end
        end
        ST_ADD: begin
          if (isDigit) begin
            state_d = ST_NUM;
            term_d  = digitW;
            value_d = sum_q + digitW;
            ok_d    = 1'b1;
          end else begin
            state_d = ST_ERR;
          end
        end
        ST_MUL: begin
          if (isDigit) begin
            state_d = ST_NUM;
            term_d  = product;
            value_d = sum_q + product;
            ok_d    = 1'b1;
          end else begin
            state_d = ST_ERR;
          end
        end
        ST_ERR: begin
          state_d = ST_ERR;
        end
        default: begin
          state_d = ST_ERR;
        end
      endcase

      // Entering (or staying in) ERR clears everything but the error flag.
      if (state_d == ST_ERR) begin
        sum_d   = '0;
        term_d  = '0;
        value_d = '0;
        ok_d    = 1'b0;
        err_d   = 1'b1;
      end
    end
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_EMPTY;
      sum_q   <= '0;
      term_q  <= '0;
      value_q <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      term_q  <= term_d;
      value_q <= value_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign bus.ok    = ok_q;
  assign bus.value = value_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_expr_eval.sv
// -----------------------------------------------------------------------------
// tb_expr_eval
// Self-checking bench for expr_eval: directed scenarios plus a randomized
// character stream compared against a string-level reference model that
// re-parses the accepted characters with ordinary integer arithmetic.
// -----------------------------------------------------------------------------
module tb_expr_eval;

  localparam int VAL_W = 16;
  localparam int MASK  = (1 << VAL_W) - 1;

  logic clk = 1'b0;
  logic clr;

  expr_eval_if #(.VAL_W(VAL_W)) bus ();

  expr_eval #(.VAL_W(VAL_W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errorCount = 0;
  int checkCount = 0;

  // Reference model: the accepted characters of the current expression and
  // a sticky error bit.
  byte unsigned mChars[$];
  bit           mErr;

  function automatic bit isDigitChar(input byte unsigned c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic bit isOpChar(input byte unsigned c);
    return (c == 8'h2B) || (c == 8'h2A);
  endfunction

  // Value of the longest prefix ending in a digit, sum of products.
  function automatic int modelValue();
    int last;
    int sum;
    int term;
    if (mErr) return 0;
    last = -1;
    foreach (mChars[i]) if (isDigitChar(mChars[i])) last = i;
    if (last < 0) return 0;
    sum  = 0;
    term = int'(mChars[0]) - 48;
    for (int i = 1; i + 1 <= last; i += 2) begin
      int d;
      d = int'(mChars[i + 1]) - 48;
      if (mChars[i] == 8'h2B) begin
        sum  = (sum + term) & MASK;
        term = d;
      end else begin
        term = (term * d) & MASK;
      end
    end
    return (sum + term) & MASK;
  endfunction

  function automatic bit modelOk();
    if (mErr || mChars.size() == 0) return 1'b0;
    return isDigitChar(mChars[mChars.size() - 1]);
  endfunction

  function automatic void modelReset();
    mChars.delete();
    mErr = 1'b0;
  endfunction

  function automatic void modelAccept(input byte unsigned c);
    bit wantDigit;
    if (mErr) return;
    wantDigit = (mChars.size() == 0) || !isDigitChar(mChars[mChars.size() - 1]);
    if ((wantDigit && isDigitChar(c)) || (!wantDigit && isOpChar(c))) begin
      mChars.push_back(c);
    end else begin
      mErr = 1'b1;
      mChars.delete();
    end
  endfunction

  // Present one cycle of stimulus, let the edge take it, then settle.
  task automatic applyStimulus(input byte unsigned c, input bit vld, input bit fl);
    @(negedge clk);
    bus.in     = c;
    bus.in_vld = vld;
    bus.flush  = fl;
    @(posedge clk);
    #1;
    if (fl) modelReset();
    else if (vld) modelAccept(c);
    bus.in_vld = 1'b0;
    bus.flush  = 1'b0;
  endtask

  task automatic test_reset();
    clr        = 1'b0;
    bus.in     = 8'h00;
    bus.in_vld = 1'b0;
    bus.flush  = 1'b0;
    modelReset();
    #12;
    checkCount++;
    if (bus.ok !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL reset_ok got=%0b want=0", bus.ok);
    end
    checkCount++;
    if (bus.value !== 16'd0) begin
      errorCount++;
      $display("[TB] FAIL reset_value got=%0d want=0", bus.value);
    end
    checkCount++;
    if (bus.err !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL reset_err got=%0b want=0", bus.err);
    end
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic test_precedence();
    byte unsigned seq[5] = '{8'h31, 8'h2B, 8'h32, 8'h2A, 8'h33};
    bit           okExp[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int           valExp[5] = '{1, 1, 3, 3, 7};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(seq[i], 1'b1, 1'b0);
      checkCount++;
      if (bus.ok !== okExp[i]) begin
        errorCount++;
        $display("[TB] FAIL prec_ok[%0d] got=%0b want=%0b", i, bus.ok, okExp[i]);
      end
      checkCount++;
      if (int'(bus.value) != valExp[i]) begin
        errorCount++;
        $display("[TB] FAIL prec_value[%0d] got=%0d want=%0d", i, bus.value, valExp[i]);
      end
    end
    checkCount++;
    if (bus.err !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL prec_err got=%0b want=0", bus.err);
    end
  endtask

  task automatic test_overflow();
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h39, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'h2A, 1'b1, 1'b0);
      applyStimulus(8'h39, 1'b1, 1'b0);
    end
    checkCount++;
    if (bus.value !== 16'd7153) begin
      errorCount++;
      $display("[TB] FAIL overflow_value got=%0d want=7153", bus.value);
    end
    checkCount++;
    if (bus.ok !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL overflow_ok got=%0b want=1", bus.ok);
    end
  endtask

  task automatic test_error();
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h31, 1'b1, 1'b0);
    applyStimulus(8'h2B, 1'b1, 1'b0);
    applyStimulus(8'h2B, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checkCount++;
      if (bus.ok !== 1'b0 || bus.err !== 1'b1 || bus.value !== 16'd0) begin
        errorCount++;
        $display("[TB] FAIL error_state[%0d] got ok=%0b err=%0b value=%0d want ok=0 err=1 value=0",
                 k, bus.ok, bus.err, bus.value);
      end
      if (k == 0) applyStimulus(8'h35, 1'b1, 1'b0);
    end
  endtask

  task automatic test_idle();
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h32, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'h2B, 1'b0, 1'b0);
      checkCount++;
      if (bus.value !== 16'd2 || bus.ok !== 1'b1) begin
        errorCount++;
        $display("[TB] FAIL idle_hold[%0d] got value=%0d ok=%0b want value=2 ok=1", i, bus.value, bus.ok);
      end
    end
    applyStimulus(8'h2A, 1'b1, 1'b0);
    applyStimulus(8'h34, 1'b1, 1'b0);
    checkCount++;
    if (bus.value !== 16'd8) begin
      errorCount++;
      $display("[TB] FAIL idle_final got=%0d want=8", bus.value);
    end
  endtask

  task automatic test_async_reset();
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h33, 1'b1, 1'b0);
    applyStimulus(8'h2A, 1'b1, 1'b0);
    checkCount++;
    if (bus.value !== 16'd3) begin
      errorCount++;
      $display("[TB] FAIL areset_pre got=%0d want=3", bus.value);
    end
    @(negedge clk);
    #2;
    clr = 1'b0;
    #1;
    checkCount++;
    if (bus.ok !== 1'b0 || bus.value !== 16'd0 || bus.err !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL areset_now got ok=%0b value=%0d err=%0b want all 0", bus.ok, bus.value, bus.err);
    end
    @(negedge clk);
    clr = 1'b1;
    modelReset();
    applyStimulus(8'h36, 1'b1, 1'b0);
    checkCount++;
    if (bus.value !== 16'd6 || bus.ok !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL areset_after got value=%0d ok=%0b want value=6 ok=1", bus.value, bus.ok);
    end
  endtask

  task automatic test_flush();
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h2A, 1'b1, 1'b0);
    checkCount++;
    if (bus.err !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL flush_pre_err got=%0b want=1", bus.err);
    end
    applyStimulus(8'h37, 1'b1, 1'b1);
    checkCount++;
    if (bus.ok !== 1'b0 || bus.value !== 16'd0 || bus.err !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL flush_clear got ok=%0b value=%0d err=%0b want all 0", bus.ok, bus.value, bus.err);
    end
    applyStimulus(8'h37, 1'b1, 1'b0);
    checkCount++;
    if (bus.value !== 16'd7 || bus.ok !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL flush_after got value=%0d ok=%0b want value=7 ok=1", bus.value, bus.ok);
    end
  endtask

  task automatic test_random();
    byte unsigned others[4] = '{8'h20, 8'h2F, 8'h3A, 8'h61};
    applyStimulus(8'h00, 1'b0, 1'b1);
    for (int n = 0; n < 500; n++) begin
      byte unsigned c;
      bit           vld;
      bit           fl;
      int           r;
      int           expVal;
      r = $urandom_range(0, 99);
      if (r < 55)      c = 8'h30 + byte'($urandom_range(0, 9));
      else if (r < 93) c = ($urandom_range(0, 1) != 0) ? 8'h2B : 8'h2A;
      else             c = others[$urandom_range(0, 3)];
      vld = ($urandom_range(0, 99) < 80);
      fl  = ($urandom_range(0, 99) < 3) || (mErr && $urandom_range(0, 99) < 30);
      applyStimulus(c, vld, fl);
      expVal = modelValue();
      checkCount++;
      if (bus.ok !== modelOk() || int'(bus.value) != expVal || bus.err !== mErr) begin
        errorCount++;
        $display("[TB] FAIL random[%0d] got ok=%0b value=%0d err=%0b want ok=%0b value=%0d err=%0b",
                 n, bus.ok, bus.value, bus.err, modelOk(), expVal, mErr);
      end
      checkCount++;
      if (bus.ok === 1'b1 && bus.err === 1'b1) begin
        errorCount++;
        $display("[TB] FAIL random_okerr[%0d] got ok=1 err=1 want not both", n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_precedence();
    test_overflow();
    test_error();
    test_idle();
    test_async_reset();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
